// File: rtl/trace_chk_pkg.sv
// Shared definitions for the retire trace checker: retire-bus layout,
// error codes, FSM state encoding and the end-of-test address.
package trace_chk_pkg;

    localparam int PC_LSB    = 0;
    localparam int WDATA_LSB = 32;
    localparam int WADDR_LSB = 64;
    localparam int RF_EN_BIT = 69;
    localparam int REC_W     = 69;
    localparam int RETIRE_W  = 70;

    localparam logic [31:0] END_ADDR = 32'h0000_000C;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_PC        = 3'd1;
    localparam logic [2:0] ERR_WADDR     = 3'd2;
    localparam logic [2:0] ERR_WDATA     = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd5;
    localparam logic [2:0] ERR_END_VALUE = 3'd6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO buffering retire records; a push is accepted while full
// when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/retire_trace_checker.sv
// Compares DUT retire events against a golden record stream and reports a
// registered pass/fail verdict with first-error capture.
module retire_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RETIRE_W-1:0] inst_retire,
    input  logic                mem_wen,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic                gold_valid,
    input  logic [31:0]         gold_pc,
    input  logic [4:0]          gold_waddr,
    input  logic [31:0]         gold_wdata,
    input  logic [31:0]         gold_mask,
    output logic                gold_ready,
    output logic                done,
    output logic                pass,
    output logic [2:0]          err_code,
    output logic [31:0]         err_pc,
    output logic [31:0]         err_expected,
    output logic [31:0]         err_actual,
    output logic [31:0]         retire_count
);

    chk_state_t                   state;
    logic [31:0]                  end_value;
    logic [31:0]                  drain_cnt;
    logic [REC_W-1:0]             head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         retire_ev;
    logic                         push;
    logic                         consume;
    logic                         overflow;
    logic                         end_det;
    logic [31:0]                  head_pc;
    logic [31:0]                  head_wdata;
    logic [4:0]                   head_waddr;
    logic [2:0]                   mis_code;
    logic [31:0]                  mis_exp;
    logic [31:0]                  mis_act;

    assign retire_ev  = inst_retire[RF_EN_BIT] && (inst_retire[WADDR_LSB +: 5] != '0);
    assign push       = retire_ev && (state == ST_RUN);
    assign gold_ready = !rst && ((state == ST_RUN) || (state == ST_DRAIN)) && (fifo_count != '0);
    assign consume    = gold_valid && gold_ready;
    assign overflow   = push && fifo_full && !consume;
    assign end_det    = (state == ST_RUN) && mem_wen && (mem_addr == END_ADDR);

    assign head_pc    = head[PC_LSB +: 32];
    assign head_wdata = head[WDATA_LSB +: 32];
    assign head_waddr = head[WADDR_LSB +: 5];

    trace_fifo #(
        .WIDTH(REC_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (consume),
        .wdata (inst_retire[REC_W-1:0]),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // First mismatching field wins: pc, then waddr, then masked wdata.
    always_comb begin
        mis_code = ERR_NONE;
        mis_exp  = '0;
        mis_act  = '0;
        if (head_pc != gold_pc) begin
            mis_code = ERR_PC;
            mis_exp  = gold_pc;
            mis_act  = head_pc;
        end else if (head_waddr != gold_waddr) begin
            mis_code = ERR_WADDR;
            mis_exp  = {27'd0, gold_waddr};
            mis_act  = {27'd0, head_waddr};
        end else if (((head_wdata ^ gold_wdata) & gold_mask) != '0) begin
            mis_code = ERR_WDATA;
            mis_exp  = gold_wdata;
            mis_act  = head_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_code     <= ERR_NONE;
            err_pc       <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            retire_count <= '0;
            drain_cnt    <= '0;
            end_value    <= '0;
        end else begin
            case (state)
                ST_RUN, ST_DRAIN: begin
                    if (consume && (mis_code != ERR_NONE)) begin
                        state        <= ST_FAIL;
                        done         <= 1'b1;
                        err_code     <= mis_code;
                        err_pc       <= head_pc;
                        err_expected <= mis_exp;
                        err_actual   <= mis_act;
                    end else begin
                        if (consume && (retire_count != '1)) begin
                            retire_count <= retire_count + 32'd1;
                        end
                        if (state == ST_RUN) begin
                            if (overflow) begin
                                state    <= ST_FAIL;
                                done     <= 1'b1;
                                err_code <= ERR_OVERFLOW;
                            end else if (end_det) begin
                                state     <= ST_DRAIN;
                                end_value <= mem_wdata;
                                drain_cnt <= '0;
                            end
                        end else if (fifo_empty) begin
                            done <= 1'b1;
                            if (end_value == '0) begin
                                state <= ST_PASS;
                                pass  <= 1'b1;
                            end else begin
                                state    <= ST_FAIL;
                                err_code <= ERR_END_VALUE;
                            end
                        end else if (consume) begin
                            drain_cnt <= '0;
                        end else if (drain_cnt == 32'(DRAIN_TIMEOUT - 1)) begin
                            state    <= ST_FAIL;
                            done     <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                        end else begin
                            drain_cnt <= drain_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
